instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
- Inverse of the instruction decoder: accepts field-level instruction descriptions over a valid/ready handshake and packs them into 32-bit instruction words.
- Writes the words sequentially into instruction memory (program loader / testbench program builder side of the core).
- Automatically pads NOP delay slots after every branch.
- Tracks fill level; flags overflow and illegal-kind errors.

Parameters:
ADDR_W, 8, instruction-memory address width
DEPTH, 256, maximum words written; must be <= 2**ADDR_W
BASE_ADDR, 0, imem address of the first word
PAD_NOPS, 2, NOP words inserted after each branch (0 allowed)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept this cycle
in_kind  input  3  0=R-type, 1=VBNZ, 2=VBEZ, 3=LD, 4=SD, 5=NOP, 6/7 illegal
in_rd  input  5  destination register (R-type, LD)
in_ra  input  5  source A (R-type, branch register, SD data register)
in_rb  input  5  source B (R-type)
in_ww  input  5  write-width field (R-type)
in_op  input  6  operation code (R-type)
in_imm  input  16  branch immediate or memory address
finish  input  1  end of program request
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  write address
imem_wdata  output  32  encoded instruction
word_count  output  ADDR_W+1  words written since reset
done  output  1  program closed, sticky
overflow  output  1  sticky: write attempted or pad truncated at DEPTH
illegal  output  1  sticky: kind 6/7 received

Behaviour:
- Reset: all outputs 0 except in_ready=1; state ACCEPT; word_count=0; pad counter and finish_pending cleared. Reset mid-padding discards the remaining pads.
- Encoding, fields not listed are 0:
  - R-type: [31:26]=101010, [25:21]=rd, [20:16]=ra, [15:11]=rb, [10:6]=ww, [5:0]=op.
  - VBNZ: 100010, [25:21]=ra, [15:0]=imm.
  - VBEZ: 100011, [25:21]=ra, [15:0]=imm.
  - LD: 100000, [25:21]=rd, [15:0]=imm.
  - SD: 100001, [25:21]=ra, [15:0]=imm.
  - NOP: 0xF0000000.
- Handshake: transfer when in_valid && in_ready. Registered output, 1-cycle latency: the next cycle has imem_we=1, imem_addr=BASE_ADDR+word_count(old), imem_wdata=encoded word. word_count increments at the same time. imem_we is 0 in every cycle with no write.
- in_ready = (state==ACCEPT) && (word_count<DEPTH) && !finish_pending.
- Illegal kind: accepted, nothing written, illegal set.
- States:
  - ACCEPT: handshake accepted. A branch accepted with PAD_NOPS>0 goes to PAD with pad_cnt=PAD_NOPS.
  - PAD: one NOP written per cycle; pad_cnt decrements; return to ACCEPT when pad_cnt reaches 1. If word_count==DEPTH before all pads are written, remaining pads are dropped, overflow is set, and the state returns to ACCEPT.
  - DONE: in_ready=0, done=1, no writes until reset.
- finish: latched into finish_pending in any state. Leave for DONE from ACCEPT when finish_pending=1 and no pad is owed. finish in the same cycle as an accepted branch: the branch and all its pads are written first, then DONE. No terminating word is added.
- Full: in ACCEPT, in_valid=1 while word_count==DEPTH sets overflow; no write occurs.

Test Plan:
- R-type rd=3, ra=1, rb=2, ww=2, op=0x01 -> next cycle imem_we=1, addr 0, wdata 0xA8611081; word_count=1.
- VBNZ ra=5, imm=0x0010, PAD_NOPS=2 -> 0x88A00010 @0, 0xF0000000 @1, 0xF0000000 @2; in_ready low for 2 cycles; a following LD is held off and lands @3.
- LD rd=7, imm=0x0040 then SD ra=4, imm=0x0041 back-to-back -> 0x80E00040 @0, 0x84800041 @1; kind=6 afterwards -> illegal=1, no write, word_count stays 2.
- DEPTH=4: four NOPs written, then in_ready=0 and word_count=4; in_valid held -> overflow=1, imem_we stays 0. Second bench with DEPTH=3: VBNZ at word_count 1 -> one pad written, overflow=1.
- finish asserted in the same cycle as VBEZ ra=2, imm=0xFFFC -> 0x8C40FFFC, then 2 NOPs; done=1 the cycle after the last pad; in_ready stays 0.
- reset asserted during the PAD state -> next cycle imem_we=0, word_count=0, in_ready=1, done/overflow/illegal=0; new R-type written to addr 0.

Source files
------------

// File: rtl/instr_stream_encoder.sv
// Packs field-level instruction descriptions into 32-bit words and streams them into
// instruction memory, padding NOP delay slots after branches and flagging overflow/illegal kinds.
module instr_stream_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned PAD_NOPS  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_ra,
  input  logic [4:0]        in_rb,
  input  logic [4:0]        in_ww,
  input  logic [5:0]        in_op,
  input  logic [15:0]       in_imm,
  input  logic              finish,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              overflow,
  output logic              illegal
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned PAD_W = $clog2(PAD_NOPS + 2);

  localparam logic [2:0] K_RTYPE = 3'd0;
  localparam logic [2:0] K_VBNZ  = 3'd1;
  localparam logic [2:0] K_VBEZ  = 3'd2;
  localparam logic [2:0] K_LD    = 3'd3;
  localparam logic [2:0] K_SD    = 3'd4;
  localparam logic [31:0] NOP_WORD = 32'hF000_0000;

  typedef enum logic [1:0] {ACCEPT, PAD, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic [PAD_W-1:0]   pad_cnt_q, pad_cnt_d;
  logic               finish_pending_q, finish_pending_d;
  logic               in_ready_q, in_ready_d;
  logic               imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic               illegal_q, illegal_d;
  logic               write_c;
  logic [31:0]        word_c;

  // Field packing for every legal kind; unlisted fields stay zero.
  function automatic logic [31:0] encode(input logic [2:0] kind, input logic [4:0] rd,
                                         input logic [4:0] ra, input logic [4:0] rb,
                                         input logic [4:0] ww, input logic [5:0] op,
                                         input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    case (kind)
      K_RTYPE: w = {6'b101010, rd, ra, rb, ww, op};
      K_VBNZ:  w = {6'b100010, ra, 5'd0, imm};
      K_VBEZ:  w = {6'b100011, ra, 5'd0, imm};
      K_LD:    w = {6'b100000, rd, 5'd0, imm};
      K_SD:    w = {6'b100001, ra, 5'd0, imm};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ACCEPT;
      word_count_q     <= '0;
      pad_cnt_q        <= '0;
      finish_pending_q <= 1'b0;
      in_ready_q       <= 1'b1;
      imem_we_q        <= 1'b0;
      imem_addr_q      <= '0;
      imem_wdata_q     <= '0;
      done_q           <= 1'b0;
      overflow_q       <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      word_count_q     <= word_count_d;
      pad_cnt_q        <= pad_cnt_d;
      finish_pending_q <= finish_pending_d;
      in_ready_q       <= in_ready_d;
      imem_we_q        <= imem_we_d;
      imem_addr_q      <= imem_addr_d;
      imem_wdata_q     <= imem_wdata_d;
      done_q           <= done_d;
      overflow_q       <= overflow_d;
      illegal_q        <= illegal_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    word_count_d     = word_count_q;
    pad_cnt_d        = pad_cnt_q;
    finish_pending_d = finish_pending_q | finish;
    imem_we_d        = 1'b0;
    imem_addr_d      = imem_addr_q;
    imem_wdata_d     = imem_wdata_q;
    overflow_d       = overflow_q;
    illegal_d        = illegal_q;
    write_c          = 1'b0;
    word_c           = NOP_WORD;

    case (state_q)
      ACCEPT: begin
        if (finish_pending_q) begin
          state_d = DONE;
        end else if (in_valid && in_ready_q) begin
          if (in_kind >= 3'd6) begin
            illegal_d = 1'b1;
          end else begin
            write_c = 1'b1;
            word_c  = encode(in_kind, in_rd, in_ra, in_rb, in_ww, in_op, in_imm);
            if ((in_kind == K_VBNZ || in_kind == K_VBEZ) && PAD_NOPS > 0) begin
              state_d   = PAD;
              pad_cnt_d = PAD_W'(PAD_NOPS);
            end
          end
        end else if (in_valid && word_count_q == CNT_W'(DEPTH)) begin
          overflow_d = 1'b1;
        end
      end
      PAD: begin
        // Memory full mid-padding: drop the owed NOPs.
        if (word_count_q == CNT_W'(DEPTH)) begin
          overflow_d = 1'b1;
          pad_cnt_d  = '0;
          state_d    = ACCEPT;
        end else begin
          write_c   = 1'b1;
          pad_cnt_d = pad_cnt_q - PAD_W'(1);
          if (pad_cnt_q == PAD_W'(1)) state_d = ACCEPT;
        end
      end
      default: ;
    endcase

    if (write_c) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = ADDR_W'(BASE_ADDR) + word_count_q[ADDR_W-1:0];
      imem_wdata_d = word_c;
      word_count_d = word_count_q + CNT_W'(1);
    end

    done_d     = (state_d == DONE);
    in_ready_d = (state_d == ACCEPT) && (word_count_d < CNT_W'(DEPTH)) && !finish_pending_d;
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: one default instance plus DEPTH=4 and DEPTH=3
// instances sharing the same stimulus; each scenario checks the instance it targets.
module tb_instr_stream_encoder;

  logic        clk, reset, in_valid, finish;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd, in_ra, in_rb, in_ww;
  logic [5:0]  in_op;
  logic [15:0] in_imm;

  logic m_rdy, m_we, m_done, m_ovf, m_ill;
  logic [7:0] m_addr;
  logic [31:0] m_wdata;
  logic [8:0] m_wc;
  logic f4_rdy, f4_we, f4_done, f4_ovf, f4_ill;
  logic [7:0] f4_addr;
  logic [31:0] f4_wdata;
  logic [8:0] f4_wc;
  logic f3_rdy, f3_we, f3_done, f3_ovf, f3_ill;
  logic [7:0] f3_addr;
  logic [31:0] f3_wdata;
  logic [8:0] f3_wc;

  int checks = 0;
  int passed = 0;

  instr_stream_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_rdy), .in_kind(in_kind),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_ww(in_ww), .in_op(in_op), .in_imm(in_imm),
    .finish(finish), .imem_we(m_we), .imem_addr(m_addr), .imem_wdata(m_wdata),
    .word_count(m_wc), .done(m_done), .overflow(m_ovf), .illegal(m_ill));

  instr_stream_encoder #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(f4_rdy), .in_kind(in_kind),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_ww(in_ww), .in_op(in_op), .in_imm(in_imm),
    .finish(finish), .imem_we(f4_we), .imem_addr(f4_addr), .imem_wdata(f4_wdata),
    .word_count(f4_wc), .done(f4_done), .overflow(f4_ovf), .illegal(f4_ill));

  instr_stream_encoder #(.DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(f3_rdy), .in_kind(in_kind),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_ww(in_ww), .in_op(in_op), .in_imm(in_imm),
    .finish(finish), .imem_we(f3_we), .imem_addr(f3_addr), .imem_wdata(f3_wdata),
    .word_count(f3_wc), .done(f3_done), .overflow(f3_ovf), .illegal(f3_ill));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] ra,
                       input logic [4:0] rb, input logic [4:0] ww, input logic [5:0] op,
                       input logic [15:0] imm);
    in_valid = 1'b1; in_kind = k; in_rd = rd; in_ra = ra; in_rb = rb;
    in_ww = ww; in_op = op; in_imm = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0; finish = 1'b0; in_kind = 3'd0; in_rd = '0; in_ra = '0;
    in_rb = '0; in_ww = '0; in_op = '0; in_imm = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_rdy !== 1'b1) $display("FAIL reset_ready got %0b exp 1", m_rdy); else passed++;
    checks++; if ({m_we, m_done, m_ovf, m_ill} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {m_we, m_done, m_ovf, m_ill}); else passed++;
    checks++; if (m_wc !== 9'd0) $display("FAIL reset_wc got %0d exp 0", m_wc); else passed++;
  endtask

  task automatic test_rtype();
    do_reset();
    drive(3'd0, 5'd3, 5'd1, 5'd2, 5'd2, 6'h01, 16'h0);
    tick();
    idle();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd0) $display("FAIL rtype_we_addr got we=%0b addr=%0d exp we=1 addr=0", m_we, m_addr); else passed++;
    checks++; if (m_wdata !== 32'hA861_1081) $display("FAIL rtype_wdata got %h exp a8611081", m_wdata); else passed++;
    checks++; if (m_wc !== 9'd1) $display("FAIL rtype_wc got %0d exp 1", m_wc); else passed++;
    tick();
    checks++; if (m_we !== 1'b0) $display("FAIL rtype_idle_we got %0b exp 0", m_we); else passed++;
  endtask

  task automatic test_branch_pad();
    do_reset();
    drive(3'd1, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0010);
    tick();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd0 || m_wdata !== 32'h88A0_0010) $display("FAIL vbnz_word got we=%0b addr=%0d data=%h exp 1/0/88a00010", m_we, m_addr, m_wdata); else passed++;
    checks++; if (m_rdy !== 1'b0) $display("FAIL vbnz_ready1 got %0b exp 0", m_rdy); else passed++;
    drive(3'd3, 5'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0005);
    tick();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd1 || m_wdata !== 32'hF000_0000) $display("FAIL vbnz_pad1 got we=%0b addr=%0d data=%h exp 1/1/f0000000", m_we, m_addr, m_wdata); else passed++;
    checks++; if (m_rdy !== 1'b0) $display("FAIL vbnz_ready2 got %0b exp 0", m_rdy); else passed++;
    tick();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd2 || m_wdata !== 32'hF000_0000) $display("FAIL vbnz_pad2 got we=%0b addr=%0d data=%h exp 1/2/f0000000", m_we, m_addr, m_wdata); else passed++;
    checks++; if (m_rdy !== 1'b1) $display("FAIL vbnz_ready3 got %0b exp 1", m_rdy); else passed++;
    tick();
    idle();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd3 || m_wdata !== 32'h8020_0005) $display("FAIL held_ld got we=%0b addr=%0d data=%h exp 1/3/80200005", m_we, m_addr, m_wdata); else passed++;
    checks++; if (m_wc !== 9'd4) $display("FAIL branch_wc got %0d exp 4", m_wc); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(3'd3, 5'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0040);
    tick();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd0 || m_wdata !== 32'h80E0_0040) $display("FAIL ld_word got we=%0b addr=%0d data=%h exp 1/0/80e00040", m_we, m_addr, m_wdata); else passed++;
    drive(3'd4, 5'd0, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0041);
    tick();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd1 || m_wdata !== 32'h8480_0041) $display("FAIL sd_word got we=%0b addr=%0d data=%h exp 1/1/84800041", m_we, m_addr, m_wdata); else passed++;
    checks++; if (m_ill !== 1'b0) $display("FAIL pre_illegal got %0b exp 0", m_ill); else passed++;
    drive(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1);
    tick();
    idle();
    checks++; if (m_ill !== 1'b1) $display("FAIL illegal_flag got %0b exp 1", m_ill); else passed++;
    checks++; if (m_we !== 1'b0 || m_wc !== 9'd2) $display("FAIL illegal_nowrite got we=%0b wc=%0d exp 0/2", m_we, m_wc); else passed++;
  endtask

  task automatic test_depth4_full();
    do_reset();
    drive(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (f4_we !== 1'b1 || f4_addr !== 8'(i) || f4_wdata !== 32'hF000_0000) $display("FAIL d4_nop%0d got we=%0b addr=%0d data=%h exp 1/%0d/f0000000", i, f4_we, f4_addr, f4_wdata, i); else passed++;
    end
    checks++; if (f4_rdy !== 1'b0 || f4_wc !== 9'd4) $display("FAIL d4_full got rdy=%0b wc=%0d exp 0/4", f4_rdy, f4_wc); else passed++;
    checks++; if (f4_ovf !== 1'b0) $display("FAIL d4_ovf_early got %0b exp 0", f4_ovf); else passed++;
    tick();
    checks++; if (f4_ovf !== 1'b1 || f4_we !== 1'b0) $display("FAIL d4_overflow got ovf=%0b we=%0b exp 1/0", f4_ovf, f4_we); else passed++;
    tick();
    idle();
    checks++; if (f4_we !== 1'b0 || f4_wc !== 9'd4) $display("FAIL d4_stay got we=%0b wc=%0d exp 0/4", f4_we, f4_wc); else passed++;
  endtask

  task automatic test_depth3_pad_trunc();
    do_reset();
    drive(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0);
    tick();
    drive(3'd1, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0010);
    tick();
    idle();
    checks++; if (f3_we !== 1'b1 || f3_addr !== 8'd1 || f3_wdata !== 32'h88A0_0010) $display("FAIL d3_branch got we=%0b addr=%0d data=%h exp 1/1/88a00010", f3_we, f3_addr, f3_wdata); else passed++;
    tick();
    checks++; if (f3_we !== 1'b1 || f3_addr !== 8'd2 || f3_ovf !== 1'b0) $display("FAIL d3_pad got we=%0b addr=%0d ovf=%0b exp 1/2/0", f3_we, f3_addr, f3_ovf); else passed++;
    tick();
    checks++; if (f3_we !== 1'b0 || f3_ovf !== 1'b1 || f3_wc !== 9'd3) $display("FAIL d3_trunc got we=%0b ovf=%0b wc=%0d exp 0/1/3", f3_we, f3_ovf, f3_wc); else passed++;
  endtask

  task automatic test_finish_branch();
    do_reset();
    drive(3'd2, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFC);
    finish = 1'b1;
    tick();
    idle();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd0 || m_wdata !== 32'h8C40_FFFC) $display("FAIL fin_branch got we=%0b addr=%0d data=%h exp 1/0/8c40fffc", m_we, m_addr, m_wdata); else passed++;
    tick();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd1 || m_wdata !== 32'hF000_0000) $display("FAIL fin_pad1 got we=%0b addr=%0d data=%h exp 1/1/f0000000", m_we, m_addr, m_wdata); else passed++;
    tick();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd2 || m_done !== 1'b0 || m_rdy !== 1'b0) $display("FAIL fin_pad2 got we=%0b addr=%0d done=%0b rdy=%0b exp 1/2/0/0", m_we, m_addr, m_done, m_rdy); else passed++;
    tick();
    checks++; if (m_done !== 1'b1 || m_we !== 1'b0 || m_rdy !== 1'b0) $display("FAIL fin_done got done=%0b we=%0b rdy=%0b exp 1/0/0", m_done, m_we, m_rdy); else passed++;
    drive(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0);
    tick();
    tick();
    idle();
    checks++; if (m_done !== 1'b1 || m_we !== 1'b0 || m_wc !== 9'd3) $display("FAIL fin_sticky got done=%0b we=%0b wc=%0d exp 1/0/3", m_done, m_we, m_wc); else passed++;
  endtask

  task automatic test_reset_mid_pad();
    do_reset();
    drive(3'd1, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0010);
    tick();
    idle();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (m_we !== 1'b0 || m_wc !== 9'd0 || m_rdy !== 1'b1) $display("FAIL rst_pad got we=%0b wc=%0d rdy=%0b exp 0/0/1", m_we, m_wc, m_rdy); else passed++;
    checks++; if ({m_done, m_ovf, m_ill} !== 3'b0) $display("FAIL rst_pad_flags got %b exp 000", {m_done, m_ovf, m_ill}); else passed++;
    tick();
    checks++; if (m_we !== 1'b0) $display("FAIL rst_pad_nopad got we=%0b exp 0", m_we); else passed++;
    drive(3'd0, 5'd3, 5'd1, 5'd2, 5'd2, 6'h01, 16'h0);
    tick();
    idle();
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd0 || m_wdata !== 32'hA861_1081) $display("FAIL rst_pad_rtype got we=%0b addr=%0d data=%h exp 1/0/a8611081", m_we, m_addr, m_wdata); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_rtype();
    test_branch_pad();
    test_back_to_back();
    test_depth4_full();
    test_depth3_pad_trunc();
    test_finish_branch();
    test_reset_mid_pad();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
